// File: rtl/reaction_timer.sv
// Drag-race reaction timer: measures green-to-launch time in ms as 4-digit BCD
// and flags a red-light foul when launch comes before green while staged.
module reaction_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        SL,
    input  logic        G,
    input  logic        launch,
    output logic [15:0] bcd,
    output logic        running,
    output logic        done,
    output logic        foul,
    output logic        over
);

    // state    | meaning
    // S_IDLE   | waiting for stage light, last result held
    // S_ARMED  | staged, waiting for green (launch here is a foul)
    // S_TIMING | green seen, counting ms until launch or 9999
    // S_DONE   | result captured (valid launch or saturated)
    // S_FOUL   | launch came before green
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_TIMING,
        S_DONE,
        S_FOUL
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic          r_launch_e;
    logic [PW-1:0] r_presc;
    logic [PW-1:0] w_presc_nxt;
    logic [15:0]   r_bcd;
    logic [15:0]   w_bcd_nxt;
    logic [15:0]   w_bcd_inc;
    logic          w_carry;
    logic          r_running;
    logic          w_running_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_foul;
    logic          w_foul_nxt;
    logic          r_over;
    logic          w_over_nxt;
    logic          w_tick;

    assign w_tick = (r_presc == TC);

    // Decimal ripple increment: a digit at 9 wraps to 0 and carries on.
    always_comb begin
        w_bcd_inc = r_bcd;
        w_carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == 4'd9) begin
                    w_bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry             = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_bcd_nxt     = r_bcd;
        w_running_nxt = r_running;
        w_done_nxt    = r_done;
        w_foul_nxt    = r_foul;
        w_over_nxt    = r_over;
        case (r_state)
            S_IDLE: begin
                if (SL) begin
                    w_state_nxt = S_ARMED;
                    w_bcd_nxt   = 16'h0000;
                    w_done_nxt  = 1'b0;
                    w_foul_nxt  = 1'b0;
                    w_over_nxt  = 1'b0;
                end
            end
            S_ARMED: begin
                if (r_launch_e && !G) begin
                    w_state_nxt = S_FOUL;
                    w_foul_nxt  = 1'b1;
                end else if (r_launch_e && G) begin
                    w_state_nxt = S_DONE;
                    w_bcd_nxt   = 16'h0000;
                    w_done_nxt  = 1'b1;
                end else if (G) begin
                    w_state_nxt   = S_TIMING;
                    w_presc_nxt   = '0;
                    w_running_nxt = 1'b1;
                end else if (!SL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TIMING: begin
                w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
                // Launch wins over a coincident tick so the frozen value is what the driver saw.
                if (r_launch_e) begin
                    w_state_nxt   = S_DONE;
                    w_running_nxt = 1'b0;
                    w_done_nxt    = 1'b1;
                end else if (w_tick) begin
                    if (r_bcd == 16'h9999) begin
                        w_state_nxt   = S_DONE;
                        w_running_nxt = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_over_nxt    = 1'b1;
                    end else begin
                        w_bcd_nxt = w_bcd_inc;
                    end
                end
            end
            S_DONE, S_FOUL: begin
                if (!SL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync3    <= 1'b0;
            r_launch_e <= 1'b0;
            r_presc    <= '0;
            r_bcd      <= 16'h0000;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_foul     <= 1'b0;
            r_over     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync1    <= launch;
            r_sync2    <= r_sync1;
            r_sync3    <= r_sync2;
            r_launch_e <= r_sync2 & ~r_sync3;
            r_presc    <= w_presc_nxt;
            r_bcd      <= w_bcd_nxt;
            r_running  <= w_running_nxt;
            r_done     <= w_done_nxt;
            r_foul     <= w_foul_nxt;
            r_over     <= w_over_nxt;
        end
    end

    assign bcd     = r_bcd;
    assign running = r_running;
    assign done    = r_done;
    assign foul    = r_foul;
    assign over    = r_over;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with TICK_DIV=4 (one BCD count per 4 clocks).
module tb_reaction_timer;

    logic        clk;
    logic        reset;
    logic        SL;
    logic        G;
    logic        launch;
    logic [15:0] bcd;
    logic        running;
    logic        done;
    logic        foul;
    logic        over;

    int checks = 0;
    int errors = 0;

    reaction_timer #(.TICK_DIV(4)) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .SL      (SL),
        .G       (G),
        .launch  (launch),
        .bcd     (bcd),
        .running (running),
        .done    (done),
        .foul    (foul),
        .over    (over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int k);
        logic [15:0] r;
        r[15:12] = 4'((k / 1000) % 10);
        r[11:8]  = 4'((k / 100) % 10);
        r[7:4]   = 4'((k / 10) % 10);
        r[3:0]   = 4'(k % 10);
        return r;
    endfunction

    task automatic check_flags(input string tag, input logic [15:0] exp_bcd,
                               input logic exp_run, input logic exp_done,
                               input logic exp_foul, input logic exp_over);
        check({tag, ".bcd"}, bcd, exp_bcd);
        check({tag, ".running"}, 16'(running), 16'(exp_run));
        check({tag, ".done"}, 16'(done), 16'(exp_done));
        check({tag, ".foul"}, 16'(foul), 16'(exp_foul));
        check({tag, ".over"}, 16'(over), 16'(exp_over));
    endtask

    initial begin
        reset  = 1'b1;
        SL     = 1'b0;
        G      = 1'b0;
        launch = 1'b0;
        step(2);
        check_flags("reset", 16'h0000, 0, 0, 0, 0);
        reset = 1'b0;

        // 1: stage, green two cycles later, launch 40 cycles after green entry
        SL = 1'b1;
        step(2);
        G = 1'b1;
        step(1);
        check_flags("t1_entry", 16'h0000, 1, 0, 0, 0);
        step(37);
        check("t1_pre_launch", bcd, 16'h0009);
        launch = 1'b1;
        step(3);
        check_flags("t1_sync_latency", 16'h0010, 1, 0, 0, 0);
        step(1);
        check_flags("t1_done", 16'h0010, 0, 1, 0, 0);
        launch = 1'b0;
        step(4);
        check_flags("t1_hold", 16'h0010, 0, 1, 0, 0);

        // 6b: DONE then SL 0->1 clears result and re-arms
        SL = 1'b0;
        G  = 1'b0;
        step(1);
        check_flags("t6b_idle_held", 16'h0010, 0, 1, 0, 0);
        SL = 1'b1;
        step(1);
        check_flags("t6b_rearm", 16'h0000, 0, 0, 0, 0);

        // 2: launch while staged before green -> foul
        launch = 1'b1;
        step(3);
        check("t2_pre_foul", 16'(foul), 16'd0);
        step(1);
        check_flags("t2_foul", 16'h0000, 0, 0, 1, 0);
        G = 1'b1;
        step(5);
        check_flags("t2_green_ignored", 16'h0000, 0, 0, 1, 0);
        launch = 1'b0;
        step(4);

        // 4: launch pulse coincident with green in ARMED
        SL = 1'b0;
        G  = 1'b0;
        step(1);
        check("t4_idle_foul_held", 16'(foul), 16'd1);
        SL = 1'b1;
        step(1);
        check_flags("t4_armed", 16'h0000, 0, 0, 0, 0);
        launch = 1'b1;
        step(3);
        G = 1'b1;
        step(1);
        check_flags("t4_coincident", 16'h0000, 0, 1, 0, 0);

        // 5: reset mid-TIMING at 0123, then G alone must not start anything
        launch = 1'b0;
        G      = 1'b0;
        step(4);
        SL = 1'b0;
        step(1);
        SL = 1'b1;
        step(1);
        G = 1'b1;
        step(1);
        step(492);
        check_flags("t5_at_0123", 16'h0123, 1, 0, 0, 0);
        reset = 1'b1;
        SL    = 1'b0;
        step(1);
        check_flags("t5_reset", 16'h0000, 0, 0, 0, 0);
        reset = 1'b0;
        step(10);
        check_flags("t5_g_no_sl", 16'h0000, 0, 0, 0, 0);

        // 6a: ARMED then SL drop returns to IDLE with no flag set
        G  = 1'b0;
        SL = 1'b1;
        step(1);
        SL = 1'b0;
        step(1);
        check_flags("t6a_idle", 16'h0000, 0, 0, 0, 0);
        G = 1'b1;
        step(6);
        check_flags("t6a_g_ignored", 16'h0000, 0, 0, 0, 0);
        G = 1'b0;

        // 3: no launch, count every tick up to saturation
        SL = 1'b1;
        step(1);
        G = 1'b1;
        step(1);
        for (int k = 1; k <= 9999; k++) begin
            step(4);
            check("t3_count", bcd, to_bcd(k));
        end
        check("t3_9999_running", 16'(running), 16'd1);
        step(3);
        check_flags("t3_pre_over", 16'h9999, 1, 0, 0, 0);
        step(1);
        check_flags("t3_over", 16'h9999, 0, 1, 0, 1);
        step(8);
        check_flags("t3_over_hold", 16'h9999, 0, 1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
